// File: rtl/riscv_pkg.sv
// Shared fetch-unit definitions.
//   fetch_state_t    : instruction-fetch FSM state encoding
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0), shown after reset
//   DEFAULT_RESET_PC : default address of the first fetch after reset
package riscv_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit.
// Issues one word request at a time to instruction memory, registers the
// returned word with its PC and holds it until the decoder takes it.
// Taken branches/jumps redirect the PC; an in-flight response is killed.
// A misaligned redirect target locks the unit in S_ERR until reset.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   imem_req/addr     : memory request strobe and word address
//   imem_rvalid/rdata : memory response
//   Instr_rdata       : registered instruction for the decoder
//   instr_pc          : PC of Instr_rdata
//   instr_valid       : Instr_rdata/instr_pc hold a live instruction
//   instr_ready       : decoder consumes the instruction
//   redirect_en/pc    : branch/jump redirect request and target
//   fetch_misaligned  : sticky misaligned-redirect flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | one idle cycle after reset release
// S_REQ   | request driven at pc
// S_WAIT  | waiting for the response (dropped if kill is set)
// S_HOLD  | instruction valid, waiting for the decoder
// S_ERR   | misaligned redirect seen, frozen until reset
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_rdata,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         kill, kill_next;
  logic         load_instr;
  logic         misalign_set;
  logic         redirect_ok;
  logic         redirect_bad;

  assign redirect_ok  = redirect_en && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_en && (redirect_pc[1:0] != 2'b00);

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_RESET;
      pc               <= RESET_PC;
      kill             <= 1'b0;
      Instr_rdata      <= NOP_INSTR;
      instr_pc         <= RESET_PC;
      fetch_misaligned <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      kill  <= kill_next;
      if (load_instr) begin
        Instr_rdata <= imem_rdata;
        instr_pc    <= pc;
      end
      if (misalign_set) begin
        fetch_misaligned <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    kill_next    = kill;
    load_instr   = 1'b0;
    misalign_set = 1'b0;

    // A bad redirect wins over everything else, but S_ERR ignores all inputs.
    if (state != S_ERR && redirect_bad) begin
      misalign_set = 1'b1;
      state_next   = S_ERR;
    end else begin
      case (state)
        S_RESET: begin
          state_next = S_REQ;
          if (redirect_ok) pc_next = redirect_pc;
        end
        S_REQ: begin
          state_next = S_WAIT;
          // Request is already on the bus, so its response must be dropped.
          if (redirect_ok) begin
            pc_next   = redirect_pc;
            kill_next = 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_ok) begin
            pc_next = redirect_pc;
            if (imem_rvalid) begin
              kill_next  = 1'b0;
              state_next = S_REQ;
            end else begin
              kill_next = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill_next  = 1'b0;
              state_next = S_REQ;
            end else begin
              load_instr = 1'b1;
              state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_ok) begin
            pc_next    = redirect_pc;
            state_next = S_REQ;
          end else if (instr_ready) begin
            pc_next    = pc + 32'd4;
            state_next = S_REQ;
          end
        end
        S_ERR: begin
          state_next = S_ERR;
        end
        default: begin
          state_next = S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A memory responder answers every
// request one cycle later and pushes the expected {pc, word} into a
// scoreboard queue; each scenario task pops and compares when the fetch
// unit presents an instruction.
module tb_instr_fetch;

  localparam int          TIMEOUT  = 40;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instr_rdata;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_misaligned;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] sb_q[$];
  bit          drop_next = 1'b0;
  bit          use_bad = 1'b0;
  bit          saw_bad = 1'b0;
  bit          req_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .Instr_rdata      (Instr_rdata),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // Memory: responds in the cycle after each request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        imem_rvalid = 1'b0;
        req_prev    = 1'b0;
      end else begin
        imem_rvalid = req_prev;
        if (req_prev) begin
          imem_rdata = use_bad ? BAD_WORD : word_of(addr_prev);
          if (!drop_next) sb_q.push_back({addr_prev, imem_rdata});
          drop_next = 1'b0;
          use_bad   = 1'b0;
        end
        req_prev  = imem_req;
        addr_prev = imem_addr;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid && Instr_rdata == BAD_WORD) saw_bad = 1'b1;
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    sb_q.delete();
    drop_next = 1'b0;
    use_bad   = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      @(negedge clk);
      if (instr_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      @(negedge clk);
      if (imem_req) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    wait_valid(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL reset_first_valid: timeout waiting for instr_valid"); end
    // Async assert while an instruction is held.
    reset = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_req: got req=%b addr=%h, want req=0 addr=0", imem_req, imem_addr);
    end
    tests_run++;
    if (Instr_rdata !== NOP || instr_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_instr: got data=%h pc=%h, want data=%h pc=0", Instr_rdata, instr_pc, NOP);
    end
    tests_run++;
    if (instr_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got valid=%b misaligned=%b, want 0 0", instr_valid, fetch_misaligned);
    end
    @(posedge clk); #2; reset = 1'b0; sb_q.delete();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_cycle: got req=%b, want 0", imem_req); end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
    // Reset while a response is pending: it is lost, refetch starts at 0.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0; sb_q.delete();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_midreq_idle: got req=%b valid=%b, want 0 0", imem_req, instr_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_midreq_refetch: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [63:0] exp;
    int          last_valid;
    int          nreq;
    do_reset();
    instr_ready = 1'b1;
    exp_addr = 32'h0; exp_pc = 32'h0; last_valid = 0; nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) begin
        nreq++;
        tests_run++;
        if (imem_addr !== exp_addr) begin
          tests_failed++; $display("FAIL seq_addr: got %h, want %h", imem_addr, exp_addr);
        end
        exp_addr += 32'd4;
      end
      if (instr_valid) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL seq_instr: nothing expected, got pc=%h data=%h", instr_pc, Instr_rdata);
        end else begin
          exp = sb_q.pop_front();
          if ({instr_pc, Instr_rdata} !== exp || instr_pc !== exp_pc) begin
            tests_failed++; $display("FAIL seq_instr: got pc=%h data=%h, want pc=%h data=%h", instr_pc, Instr_rdata, exp_pc, exp[31:0]);
          end
        end
        tests_run++;
        if (c - last_valid != 3) begin
          tests_failed++; $display("FAIL seq_spacing: valid at cycle %0d, previous %0d, want gap 3", c, last_valid);
        end
        last_valid = c;
        exp_pc += 32'd4;
      end
    end
    tests_run++;
    if (nreq != 3) begin tests_failed++; $display("FAIL seq_req_count: got %0d, want 3", nreq); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [63:0] exp;
    do_reset();
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL stall_valid: timeout waiting for instr_valid");
    end else if (sb_q.size() == 0) begin
      tests_failed++; $display("FAIL stall_instr: nothing expected, got pc=%h", instr_pc);
    end else begin
      exp = sb_q.pop_front();
      if ({instr_pc, Instr_rdata} !== exp) begin
        tests_failed++; $display("FAIL stall_instr: got pc=%h data=%h, want pc=%h data=%h", instr_pc, Instr_rdata, exp[63:32], exp[31:0]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || Instr_rdata !== word_of(32'h0) || instr_pc !== 32'h0) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid=%b req=%b pc=%h data=%h, want 1 0 %h %h",
                 instr_valid, imem_req, instr_pc, Instr_rdata, 32'h0, word_of(32'h0));
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release: got req=%b addr=%h valid=%b, want 1 4 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [63:0] exp;
    do_reset();
    instr_ready = 1'b1;
    saw_bad = 1'b0;
    wait_req(ok);
    drop_next = 1'b1;
    use_bad   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (!ok || imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL rdw_wait: req_seen=%b req=%b, want req_seen=1 req=0", ok, imem_req);
    end
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rdw_refetch: got req=%b addr=%h valid=%b, want 1 100 0", imem_req, imem_addr, instr_valid);
    end
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL rdw_valid: timeout waiting for instr_valid");
    end else if (sb_q.size() == 0) begin
      tests_failed++; $display("FAIL rdw_instr: nothing expected, got pc=%h", instr_pc);
    end else begin
      exp = sb_q.pop_front();
      if ({instr_pc, Instr_rdata} !== exp || instr_pc !== 32'h100) begin
        tests_failed++; $display("FAIL rdw_instr: got pc=%h data=%h, want pc=100 data=%h", instr_pc, Instr_rdata, word_of(32'h100));
      end
    end
    tests_run++;
    if (saw_bad) begin tests_failed++; $display("FAIL rdw_killed_word: killed word %h was presented", BAD_WORD); end
  endtask

  task automatic test_redirect_req();
    bit ok;
    logic [63:0] exp;
    do_reset();
    instr_ready = 1'b1;
    wait_req(ok);
    drop_next   = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect_en = 1'b0;
    tests_run++;
    if (!ok || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rdr_wait: req_seen=%b req=%b valid=%b, want 1 0 0", ok, imem_req, instr_valid);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      tests_failed++; $display("FAIL rdr_refetch: got req=%b addr=%h, want 1 400", imem_req, imem_addr);
    end
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL rdr_valid: timeout waiting for instr_valid");
    end else if (sb_q.size() == 0) begin
      tests_failed++; $display("FAIL rdr_instr: nothing expected, got pc=%h", instr_pc);
    end else begin
      exp = sb_q.pop_front();
      if ({instr_pc, Instr_rdata} !== exp || instr_pc !== 32'h400) begin
        tests_failed++; $display("FAIL rdr_instr: got pc=%h data=%h, want pc=400 data=%h", instr_pc, Instr_rdata, word_of(32'h400));
      end
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    logic [63:0] exp;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    if (ok && sb_q.size() != 0) exp = sb_q.pop_front();
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_en = 1'b0;
    tests_run++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rdh_refetch: valid_seen=%b got req=%b addr=%h valid=%b, want 1 1 200 0", ok, imem_req, imem_addr, instr_valid);
    end
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL rdh_valid: timeout waiting for instr_valid");
    end else if (sb_q.size() == 0) begin
      tests_failed++; $display("FAIL rdh_instr: nothing expected, got pc=%h", instr_pc);
    end else begin
      exp = sb_q.pop_front();
      if ({instr_pc, Instr_rdata} !== exp || instr_pc !== 32'h200) begin
        tests_failed++; $display("FAIL rdh_instr: got pc=%h data=%h, want pc=200 data=%h", instr_pc, Instr_rdata, word_of(32'h200));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [63:0] exp;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(ok);
    if (ok && sb_q.size() != 0) exp = sb_q.pop_front();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    wait_valid(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL wrap_valid: timeout waiting for instr_valid");
    end else if (sb_q.size() == 0) begin
      tests_failed++; $display("FAIL wrap_instr: nothing expected, got pc=%h", instr_pc);
    end else begin
      exp = sb_q.pop_front();
      if ({instr_pc, Instr_rdata} !== exp || instr_pc !== 32'hFFFF_FFFC) begin
        tests_failed++; $display("FAIL wrap_instr: got pc=%h data=%h, want pc=fffffffc data=%h", instr_pc, Instr_rdata, word_of(32'hFFFF_FFFC));
      end
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_next: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    int n_active;
    logic [63:0] exp;
    do_reset();
    wait_valid(ok);
    if (ok && sb_q.size() != 0) exp = sb_q.pop_front();
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    tests_run++;
    if (!ok || fetch_misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mis_flag: valid_seen=%b got flag=%b req=%b valid=%b, want 1 1 0 0", ok, fetch_misaligned, imem_req, instr_valid);
    end
    // Everything is ignored until reset, including a good redirect.
    n_active = 0;
    redirect_pc = 32'h300;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req || instr_valid || !fetch_misaligned) n_active++;
    end
    tests_run++;
    if (n_active != 0) begin tests_failed++; $display("FAIL mis_frozen: got %0d active cycles, want 0", n_active); end
    do_reset();
    tests_run++;
    if (fetch_misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis_clear: got flag=%b, want 0", fetch_misaligned); end
    wait_req(ok);
    tests_run++;
    if (!ok || imem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL mis_refetch: req_seen=%b addr=%h, want 1 0", ok, imem_addr);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request; each asserted cycle counts as one accepted request.
REQ-005 imem_addr  output  32  word address of the request; valid while imem_req=1.
REQ-006 imem_rvalid  input  1  instruction memory response valid.
REQ-007 imem_rdata  input  32  response instruction word; sampled when imem_rvalid=1.
REQ-008 Instr_rdata  output  32  registered instruction presented to the control decoder.
REQ-009 instr_pc  output  32  PC of Instr_rdata.
REQ-010 instr_valid  output  1  Instr_rdata/instr_pc hold a live instruction.
REQ-011 instr_ready  input  1  downstream consumes the instruction when instr_valid=1.
REQ-012 redirect_en  input  1  branch/jump taken; overrides sequential PC.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 fetch_misaligned  output  1  sticky flag: redirect target not word-aligned.

Function
REQ-015 FSM states: S_RESET, S_REQ, S_WAIT, S_HOLD, S_ERR.
REQ-016 S_RESET: lasts exactly one cycle after reset release, then S_REQ; imem_req=0.
REQ-017 S_REQ: imem_req=1, imem_addr=pc; next state S_WAIT; at most one request outstanding.
REQ-018 S_WAIT: imem_req=0; on imem_rvalid=1 with kill=0, load Instr_rdata<=imem_rdata, instr_pc<=pc, go S_HOLD.
REQ-019 Minimum latency: S_REQ in cycle N, rvalid in N+1, instr_valid=1 in N+2; peak throughput one instruction per 3 cycles.
REQ-020 S_HOLD: instr_valid=1; Instr_rdata and instr_pc stable until consumed; instr_ready=1 -> pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), go S_REQ.
REQ-021 instr_valid=0 in every state except S_HOLD; Instr_rdata retains its last value when not valid.
REQ-022 Redirect (redirect_en=1, redirect_pc[1:0]=2'b00) takes priority over instr_ready in every state: pc<=redirect_pc.
REQ-023 Redirect in S_HOLD: held instruction dropped, instr_valid=0 next cycle, go S_REQ.
REQ-024 Redirect in S_REQ (request already issued): set kill, go S_WAIT.
REQ-025 Redirect in S_WAIT: set kill; if imem_rvalid=1 in the same cycle, discard that response and go S_REQ.
REQ-026 S_WAIT with kill=1: response discarded on imem_rvalid, kill cleared, go S_REQ with redirected pc.
REQ-027 Redirect with redirect_pc[1:0]!=0: pc unchanged, fetch_misaligned<=1, go S_ERR.
REQ-028 S_ERR: imem_req=0, instr_valid=0, all inputs ignored; exit only by reset.
REQ-029 imem_rvalid in S_RESET, S_REQ, S_HOLD or S_ERR is ignored.

Reset
REQ-030 Reset asynchronously forces: state S_RESET, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, Instr_rdata=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, fetch_misaligned=0.
REQ-031 Reset mid-request: any pending response is lost; the first request after release is at RESET_PC.

Structure
REQ-032 Shared package riscv_pkg holds the fetch_state_t enum, the NOP constant 32'h0000_0013 and the default reset PC.
REQ-033 Single module, no sub-modules; PC incrementer and next-PC mux are inline.

Verification
REQ-034 Reset release, rvalid one cycle after each req, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_valid every third cycle with matching instr_pc.
REQ-035 instr_ready=0 for 5 cycles in S_HOLD -> Instr_rdata/instr_pc stable, no new imem_req; ready=1 -> next req at pc+4.
REQ-036 redirect_pc=0x100 in S_WAIT, rvalid returns word 0xDEADBEEF -> word discarded, next imem_addr=0x100, instr_valid never shows 0xDEADBEEF.
REQ-037 redirect_pc=0x200 together with instr_ready=1 in S_HOLD -> next imem_addr=0x200, not pc+4.
REQ-038 redirect_pc=0x102 -> fetch_misaligned=1 next cycle, imem_req stays 0 until reset; reset clears flag and refetches RESET_PC.
REQ-039 pc=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.
